// File: rtl/estado_mascota_if.sv
// Mode-level bundle: the four 2-bit need levels
// published by the mode counters.
interface estado_mascota_if;
  logic [1:0] Nivel_Animo;
  logic [1:0] Nivel_Energia;
  logic [1:0] Nivel_Descanso;
  logic [1:0] Nivel_Medicina;

  modport master (
    output Nivel_Animo,
    output Nivel_Energia,
    output Nivel_Descanso,
    output Nivel_Medicina
  );

  modport slave (
    input Nivel_Animo,
    input Nivel_Energia,
    input Nivel_Descanso,
    input Nivel_Medicina
  );
endinterface

// File: rtl/estado_mascota.sv
// Pet-condition evaluator: synchronised need levels,
// persistence filter and priority/escalation FSM.
module estado_mascota #(
  parameter int TICKS_SEG = 50_000_000,
  parameter int T_ESTABLE = 2,
  parameter int T_CRITICO = 10
) (
  input  logic             clk,
  input  logic             B_Reset,
  input  logic             B_Test,
  estado_mascota_if.slave  niv,
  output logic [2:0]       Estado,
  output logic             Alerta,
  output logic             Muerto,
  output logic             Cambio_Estado
);

  typedef enum logic [2:0] {
    NORMAL     = 3'd0,
    TRISTE     = 3'd1,
    CANSADO    = 3'd2,
    HAMBRIENTO = 3'd3,
    ENFERMO    = 3'd4,
    CRITICO    = 3'd5,
    MUERTO     = 3'd6
  } est_t;

  localparam int TW =
    (TICKS_SEG > 1) ? $clog2(TICKS_SEG) : 1;
  localparam logic [TW-1:0] TICK_MAX =
    TW'(TICKS_SEG - 1);
  localparam logic [3:0] EST_N = 4'(T_ESTABLE);
  localparam logic [7:0] CRIT_N = 8'(T_CRITICO);

  logic [7:0]    s1, s2;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  est_t       est_q, est_d;
  est_t       cand, cand_prev_q, cand_prev_d;
  logic [3:0] stable_q, stable_d;
  logic [7:0] crit_q, crit_d;
  logic       alerta_q, alerta_d;
  logic       muerto_q, cambio_q;
  logic       upd, in_crit;
  logic [2:0] nz;

  logic [1:0] lv_a, lv_e, lv_d, lv_m;

  // Levels packed as {animo, energia, descanso, medicina}
  always_ff @(posedge clk or negedge B_Reset) begin
    if (!B_Reset) begin
      s1 <= 8'hFF;
      s2 <= 8'hFF;
    end else begin
      s1 <= {niv.Nivel_Animo, niv.Nivel_Energia,
             niv.Nivel_Descanso, niv.Nivel_Medicina};
      s2 <= s1;
    end
  end

  assign lv_a = s2[7:6];
  assign lv_e = s2[5:4];
  assign lv_d = s2[3:2];
  assign lv_m = s2[1:0];

  always_ff @(posedge clk or negedge B_Reset) begin
    if (!B_Reset) begin
      tick_cnt <= '0;
    end else if (B_Test || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = B_Test || (tick_cnt == TICK_MAX);

  always_comb begin
    nz = 3'd0;
    for (int i = 0; i < 4; i++) begin
      nz = nz + 3'(s2[2*i +: 2] == 2'd0);
    end
  end

  always_comb begin
    cand = NORMAL;
    if (nz >= 3'd2) begin
      cand = CRITICO;
    end else if (lv_m <= 2'd1) begin
      cand = ENFERMO;
    end else if (lv_e <= 2'd1) begin
      cand = HAMBRIENTO;
    end else if (lv_d <= 2'd1) begin
      cand = CANSADO;
    end else if (lv_a <= 2'd1) begin
      cand = TRISTE;
    end
  end

  assign in_crit = (est_q == CRITICO) &&
                   (cand == CRITICO);

  always_comb begin
    cand_prev_d = cand_prev_q;
    stable_d    = stable_q;
    crit_d      = crit_q;
    est_d       = est_q;
    alerta_d    = alerta_q;
    upd         = 1'b0;

    if (cand != cand_prev_q) begin
      cand_prev_d = cand;
      stable_d    = 4'd0;
    end else if (tick && stable_q < EST_N) begin
      stable_d = stable_q + 4'd1;
    end

    if (!in_crit) begin
      crit_d = 8'd0;
    end else if (tick && crit_q != CRIT_N) begin
      crit_d = crit_q + 8'd1;
    end

    // Death is absorbing and outranks the filter
    if (est_q == MUERTO) begin
      est_d = MUERTO;
    end else if (in_crit && crit_q == CRIT_N) begin
      est_d = MUERTO;
    end else if (cand == cand_prev_q &&
                 stable_q == EST_N &&
                 cand != est_q) begin
      est_d = cand;
    end

    upd = (est_d != est_q);

    if (upd) begin
      alerta_d = (est_d != NORMAL);
    end else if (est_q == CRITICO && tick) begin
      alerta_d = ~alerta_q;
    end
  end

  always_ff @(posedge clk or negedge B_Reset) begin
    if (!B_Reset) begin
      est_q       <= NORMAL;
      cand_prev_q <= NORMAL;
      stable_q    <= 4'd0;
      crit_q      <= 8'd0;
      alerta_q    <= 1'b0;
      muerto_q    <= 1'b0;
      cambio_q    <= 1'b0;
    end else begin
      est_q       <= est_d;
      cand_prev_q <= cand_prev_d;
      stable_q    <= stable_d;
      crit_q      <= crit_d;
      alerta_q    <= alerta_d;
      muerto_q    <= (est_d == MUERTO);
      cambio_q    <= upd;
    end
  end

  assign Estado        = est_q;
  assign Alerta        = alerta_q;
  assign Muerto        = muerto_q;
  assign Cambio_Estado = cambio_q;

endmodule

// File: doc/estado_mascota.md
# estado_mascota

Pet-condition evaluator on the consumer side of the mode-level interface. It reads the four 2-bit need levels (animo, energia, descanso, medicina) that the mode counters produce. It filters them with synchronisers and a persistence timer, then runs a priority state machine that decides the pet's overall condition, including escalation to a terminal "dead" state. Its outputs drive the face/status display and the alert LED.

## Interface
- TICKS_SEG, 50_000_000: clock cycles per one-second tick.
- T_ESTABLE, 2: seconds a new candidate condition must hold before `Estado` adopts it (1..15).
- T_CRITICO, 10: seconds in CRITICO with the critical condition still present before MUERTO (1..255).

Ports:
- clk  in  1  system clock; all state on rising edge.
- B_Reset  in  1  asynchronous, active-low reset.
- B_Test  in  1  test mode. When 1, the one-second tick fires every cycle.
- Nivel_Animo  in  2  mood level; 0 = empty, 3 = full.
- Nivel_Energia  in  2  energy/food level.
- Nivel_Descanso  in  2  rest level.
- Nivel_Medicina  in  2  health level.
- Estado  out  3  current condition code: 0 NORMAL, 1 TRISTE, 2 CANSADO, 3 HAMBRIENTO, 4 ENFERMO, 5 CRITICO, 6 MUERTO.
- Alerta  out  1  alert LED.
- Muerto  out  1  high while Estado == MUERTO.
- Cambio_Estado  out  1  one-cycle pulse whenever Estado changes.

## Operation
- **Level synchronisers**
  - Each level input passes through two flops (s1, s2).
  - Reset value is 2'b11, so no false alarm is raised after reset.
- **Tick generator**
  - Counter runs 0..TICKS_SEG-1; `tick` = 1 when the counter equals TICKS_SEG-1, then the counter wraps to 0.
  - With B_Test = 1, `tick` = 1 every cycle and the counter holds at 0.
- **Candidate condition**, combinational from the s2 levels. nz = number of levels equal to 0 (0..4). First match wins:
  - nz ≥ 2 → CRITICO.
  - Medicina ≤ 1 → ENFERMO.
  - Energia ≤ 1 → HAMBRIENTO.
  - Descanso ≤ 1 → CANSADO.
  - Animo ≤ 1 → TRISTE.
  - Otherwise → NORMAL.
- **Stability filter** (registers cand_prev, stable_cnt, 4 bits):
  - If cand ≠ cand_prev: cand_prev ← cand and stable_cnt ← 0.
  - Else if tick and stable_cnt < T_ESTABLE: stable_cnt ← stable_cnt+1 (saturates).
  - When cand == cand_prev, stable_cnt == T_ESTABLE, cand ≠ Estado and Estado ≠ MUERTO: Estado ← cand on that edge.
- **Critical escalation** (crit_cnt, 8 bits):
  - While Estado == CRITICO and cand == CRITICO, crit_cnt increments on each tick.
  - When crit_cnt == T_CRITICO under the same condition, Estado ← MUERTO on the next edge.
  - crit_cnt clears whenever Estado ≠ CRITICO or cand ≠ CRITICO. A partial recovery restarts the count if CRITICO is re-entered.
  - MUERTO → MUERTO takes priority over the stability filter.
- **MUERTO** is absorbing: level inputs are ignored until B_Reset.
- **Alerta**
  - 0 in NORMAL.
  - 1 steady in TRISTE, CANSADO, HAMBRIENTO, ENFERMO and MUERTO.
  - In CRITICO: set to 1 on the entry edge, then toggles on every tick.
- **Cambio_Estado** and **Muerto** are registered and updated on the same edge as Estado.

## Timing
- **Reset (B_Reset = 0, asynchronous):**
  - Estado = 0, Alerta = 0, Muerto = 0, Cambio_Estado = 0.
  - All counters = 0, cand_prev = NORMAL, synchronisers = 2'b11.
- **Release:** first active edge is the first rising clk after B_Reset goes high.
- **Level-to-Estado latency in test mode:** 4 + T_ESTABLE edges after the input changes.
  - 2 synchroniser edges, 1 cand_prev load, T_ESTABLE count edges, 1 update edge.
  - Default T_ESTABLE = 2 gives 6 edges.
- **Normal mode:** the T_ESTABLE portion becomes whole seconds, with ±1 tick of phase jitter.
- **Critical escalation:**
  - CRITICO entered on edge k → MUERTO on edge k + T_CRITICO + 1 in test mode.
  - In normal mode, after T_CRITICO..T_CRITICO+1 seconds.
- **Level glitch:** a change shorter than the filter window restarts the filter (stable_cnt ← 0) and leaves Estado unchanged.
- **Simultaneous events:** candidate change on the same edge Estado would update → no update; the filter restarts.
- **Reset mid-escalation:** immediately returns to NORMAL, the count is lost, and Cambio_Estado is not pulsed.

## Test plan
Parameters for all scenarios: B_Test = 1, T_ESTABLE = 2, T_CRITICO = 3.

1. **Reset defaults.** Reset with all levels = 3, then release → Estado = 0, Alerta = 0, Muerto = 0, and Cambio_Estado never pulses over 20 cycles.
2. **Single low need.** Energia 3→1 at edge 0 → Estado = 3 and a one-cycle Cambio_Estado pulse at edge 6, Alerta = 1. Energia back to 3 → Estado = 0 six edges later, Alerta = 0.
3. **Priority.** Medicina = 1 and Animo = 0 simultaneously → Estado = 4 (ENFERMO), not 1.
4. **Glitch rejection.** Descanso = 1 for 3 cycles, then back to 3 → Estado stays 0 and no Cambio_Estado pulse.
5. **Critical to death.**
   - Animo = 0 and Descanso = 0 → Estado = 5 at edge 6, with Alerta toggling each cycle.
   - Held → Estado = 6 and Muerto = 1 at edge 10, Alerta = 1.
   - All levels then set to 3 → Estado stays 6 until B_Reset.
6. **Recovery and reset.**
   - From CRITICO, raise Animo to 3 after 1 cycle → Estado = 2 (CANSADO) 6 edges later, never 6.
   - Re-enter CRITICO, then pulse B_Reset mid-count → outputs return to 0 asynchronously.
